// File: rtl/input_pkg.sv
// Shared constants for the input conditioner: button indices, bus widths and
// default debounce timing.
package input_pkg;

  localparam int unsigned BTN_RESET = 3;
  localparam int unsigned BTN_SET   = 2;
  localparam int unsigned BTN_LOAD  = 1;
  localparam int unsigned BTN_START = 0;

  localparam int unsigned NUM_BTN   = 4;
  localparam int unsigned NUM_SW_HI = 4;
  localparam int unsigned NUM_SW_LO = 8;
  localparam int unsigned NUM_SW    = NUM_SW_HI + NUM_SW_LO;
  localparam int unsigned NUM_CH    = NUM_BTN + NUM_SW;

  localparam int unsigned DEF_TICK_DIV     = 50000;
  localparam int unsigned DEF_STABLE_COUNT = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: multi-flop synchroniser, optional inversion, and a
// tick-qualified debounce counter that accepts a new value after a stable run.
module debounce_channel
  import input_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clkIn,
  input  logic resetIn,
  input  logic tickIn,
  input  logic rawIn,
  input  logic invertIn,
  output logic levelOut
);

  localparam int unsigned CNT_W = cnt_width(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   s_c;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rawIn};
    s_c     = sync_q[SYNC_STAGES-1] ^ invertIn;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the input agrees with the accepted value restarts qualification.
    if (s_c != level_q) begin
      cnt_d = cnt_q;
      if (tickIn) begin
        if (cnt_q == CNT_MAX) begin
          level_d = s_c;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser resets to the idle raw level so no false edge follows reset.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      sync_q  <= {SYNC_STAGES{invertIn}};
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign levelOut = level_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: shared sample-tick prescaler, 16 debounce channels
// (4 buttons + 12 switches) and registered single-cycle press pulses.
module input_conditioner
  import input_pkg::*;
#(
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned STABLE_COUNT   = DEF_STABLE_COUNT,
  parameter int unsigned BTN_ACTIVE_LOW = 1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic [NUM_BTN-1:0]   resetSetLoadStartIn,
  input  logic [NUM_SW_HI-1:0] toggleSwitches17To14In,
  input  logic [NUM_SW_LO-1:0] toggleSwitches13To6In,
  output logic [NUM_BTN-1:0]   buttonLevelOut,
  output logic [NUM_BTN-1:0]   buttonPulseOut,
  output logic [NUM_SW_HI-1:0] toggleSwitches17To14Out,
  output logic [NUM_SW_LO-1:0] toggleSwitches13To6Out,
  output logic                 sampleTickOut
);

  localparam int unsigned PRE_W = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic BTN_INV = (BTN_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [NUM_BTN-1:0] level_dly_q, level_dly_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0]  raw_c, inv_c, level_c;

  // Channel order: buttons in the low bits, then switches 13..6, then 17..14.
  assign raw_c = {toggleSwitches17To14In, toggleSwitches13To6In, resetSetLoadStartIn};
  assign inv_c = {{NUM_SW{1'b0}}, {NUM_BTN{BTN_INV}}};

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    debounce_channel #(
      .STABLE_COUNT(STABLE_COUNT),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clkIn   (clkIn),
      .resetIn (resetIn),
      .tickIn  (tick_q),
      .rawIn   (raw_c[i]),
      .invertIn(inv_c[i]),
      .levelOut(level_c[i])
    );
  end

  always_comb begin
    presc_d     = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_W'(1);
    tick_d      = (presc_d == PRE_MAX);
    level_dly_d = level_c[NUM_BTN-1:0];
    pulse_d     = level_c[NUM_BTN-1:0] & ~level_dly_q;
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      level_dly_q <= '0;
      pulse_q     <= '0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
    end
  end

  assign buttonLevelOut          = level_c[NUM_BTN-1:0];
  assign buttonPulseOut          = pulse_q;
  assign toggleSwitches13To6Out  = level_c[NUM_BTN+NUM_SW_LO-1:NUM_BTN];
  assign toggleSwitches17To14Out = level_c[NUM_CH-1:NUM_BTN+NUM_SW_LO];
  assign sampleTickOut           = tick_q;

endmodule
